// File: rtl/attention_score_normalizer.sv
// Buffers one group of signed attention scores, finds the group maximum and streams
// linear-window weights with the group sum. Optional build macro: ATTN_NORM_SKIP_ZERO_EN.
module attention_score_normalizer #(
    parameter int     NUM_KEYS = 6,
    parameter int     SCORE_W  = 64,
    parameter int     OUT_W    = 32,
    parameter longint RANGE    = 65536,
    localparam int    SUM_W    = OUT_W + $clog2(NUM_KEYS + 1),
    localparam int    IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SCORE_W-1:0] s_score,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_weight,
    output logic [SUM_W-1:0]   m_sum,
    output logic [IDX_W-1:0]   m_index,
    output logic               m_last,
    output logic               err_len
);

    localparam int                 CNT_W     = $clog2(NUM_KEYS + 1);
    localparam logic [SCORE_W-1:0] MOST_NEG  = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [SCORE_W:0]   RANGE_X   = (SCORE_W+1)'(RANGE);
    localparam logic [CNT_W-1:0]   LAST_SLOT = CNT_W'(NUM_KEYS - 1);

    typedef enum logic [1:0] {COLLECT, SUM, EMIT} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, len;
    logic signed [SCORE_W-1:0] max_q;
    logic [SUM_W-1:0]          sum_q;
    logic [IDX_W-1:0]          sum_idx, emit_idx, emit_idx_nxt, first_idx;
    logic [SCORE_W-1:0]        score_buf [NUM_KEYS];
    logic [OUT_W-1:0]          weight_buf [NUM_KEYS];

    logic               s_xfer, m_xfer, close_group, sum_done, emit_done, last_beat;
    logic [SCORE_W-1:0] sum_score;
    logic [SCORE_W:0]   diff;
    logic [OUT_W-1:0]   weight;

    assign s_xfer      = s_valid && (state == COLLECT);
    assign m_xfer      = m_ready && (state == EMIT);
    assign close_group = s_xfer && (s_last || cnt == LAST_SLOT);
    assign sum_done    = (state == SUM) && (CNT_W'(sum_idx) == len - 1'b1);
    assign emit_done   = m_xfer && last_beat;

    // One extra bit on the difference lets max=+2^63-1 against -2^63 resolve without wrap.
    always_comb begin
        sum_score = score_buf[sum_idx];
        diff      = {max_q[SCORE_W-1], max_q} - {sum_score[SCORE_W-1], sum_score};
        weight    = (diff >= RANGE_X) ? '0 : OUT_W'(RANGE_X - diff);
    end

`ifdef ATTN_NORM_SKIP_ZERO_EN
    logic [NUM_KEYS-1:0] nz_mask, nz_mask_sum;
    logic                has_next;

    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        nz_mask_sum = nz_mask;
        if (state == SUM) nz_mask_sum[sum_idx] = (weight != '0);
        first_idx    = '0;
        emit_idx_nxt = '0;
        has_next     = 1'b0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (nz_mask_sum[k]) first_idx = IDX_W'(k);
            if (nz_mask[k] && IDX_W'(k) > emit_idx) begin
                emit_idx_nxt = IDX_W'(k);
                has_next     = 1'b1;
            end
        end
        last_beat = !has_next;
    end

    always_ff @(posedge clk) begin
        if (rst || emit_done) nz_mask <= '0;
        else if (state == SUM) nz_mask <= nz_mask_sum;
    end
`else
    always_comb begin
        first_idx    = '0;
        emit_idx_nxt = emit_idx + 1'b1;
        last_beat    = (CNT_W'(emit_idx) == len - 1'b1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_weight  = '0;
        m_sum     = '0;
        m_index   = '0;
        m_last    = 1'b0;
        case (state)
            COLLECT: begin
                s_ready = !rst;
                if (close_group) state_nxt = SUM;
            end
            SUM: begin
                if (sum_done) state_nxt = EMIT;
            end
            EMIT: begin
                m_valid  = 1'b1;
                m_weight = weight_buf[emit_idx];
                m_sum    = sum_q;
                m_index  = emit_idx;
                m_last   = last_beat;
                if (emit_done) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // NOTE: the buffers carry no reset; every entry is written within a group before it is read.
    always_ff @(posedge clk) begin
        if (s_xfer)        score_buf[IDX_W'(cnt)] <= s_score;
        if (state == SUM)  weight_buf[sum_idx]    <= weight;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            len      <= '0;
            max_q    <= MOST_NEG;
            sum_q    <= '0;
            sum_idx  <= '0;
            emit_idx <= '0;
            err_len  <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                COLLECT: begin
                    if (s_xfer) begin
                        cnt <= cnt + 1'b1;
                        if ($signed(s_score) > max_q) max_q <= s_score;
                        if (close_group) begin
                            len     <= cnt + 1'b1;
                            sum_idx <= '0;
                            err_len <= !s_last;
                        end
                    end
                end
                SUM: begin
                    sum_q   <= sum_q + SUM_W'(weight);
                    sum_idx <= sum_idx + 1'b1;
                    if (sum_done) emit_idx <= first_idx;
                end
                EMIT: begin
                    if (m_xfer) begin
                        if (last_beat) begin
                            cnt      <= '0;
                            sum_q    <= '0;
                            max_q    <= MOST_NEG;
                            emit_idx <= '0;
                        end else begin
                            emit_idx <= emit_idx_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
